// File: rtl/bram_pkg.sv
// -----------------------------------------------------------------------------
// bram_pkg
//   Shared defaults for the dual-port track-buffer RAM.
//   BRAM_DW    : default data width in bits (both ports)
//   BRAM_AW    : default address width; depth = 2**BRAM_AW words
//   BRAM_DEPTH : default depth derived from BRAM_AW
// -----------------------------------------------------------------------------
package bram_pkg;
   localparam int BRAM_DW    = 8;
   localparam int BRAM_AW    = 10;
   localparam int BRAM_DEPTH = 1 << BRAM_AW;
endpackage

// File: rtl/bram_dp.sv
// -----------------------------------------------------------------------------
// bram_dp
//   True dual-port synchronous block RAM on a single clock. Port A is the SD
//   DMA side, port B the disk controller side of the track buffer.
//
//   Ports
//     clk        : single clock, all logic on the rising edge
//     reset_n    : asynchronous active-low reset; clears the read outputs only,
//                  the array is never cleared and no write happens while low
//     address_a  : port A word address          address_b : port B word address
//     data_a     : port A write data             data_b    : port B write data
//     wren_a     : port A write enable           wren_b    : port B write enable
//     enable_a   : port A clock enable           enable_b  : port B clock enable
//     q_a        : port A registered read data   q_b       : port B registered read data
//
//   Behaviour
//     Read-first on both ports: a read returns the contents before any write
//     on the same edge, from either port. If both ports write one address on
//     the same edge, port B's data is stored.
//
//   Configuration
//     BRAM_OUTREG_EN : when defined, adds a second output register per port
//                      (read latency 2), gated by enable_x and cleared by
//                      reset_n. Undefined (default): read latency 1.
// -----------------------------------------------------------------------------
module bram_dp
   import bram_pkg::*;
#(
   parameter int width_a   = BRAM_DW,
   parameter int widthad_a = BRAM_AW
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [widthad_a-1:0] address_a,
   input  logic [width_a-1:0]   data_a,
   input  logic                 wren_a,
   input  logic                 enable_a,
   output logic [width_a-1:0]   q_a,
   input  logic [widthad_a-1:0] address_b,
   input  logic [width_a-1:0]   data_b,
   input  logic                 wren_b,
   input  logic                 enable_b,
   output logic [width_a-1:0]   q_b
);

   localparam int DEPTH = 1 << widthad_a;

   // Power-up contents are all zeros; nothing in this module ever clears it.
   logic [width_a-1:0] mem [0:DEPTH-1] = '{default: '0};

   logic                port_en_a;
   logic                port_en_b;
   logic                wr_en_a;
   logic                wr_en_b;
   logic [width_a-1:0]  rd_a_p1;
   logic [width_a-1:0]  rd_b_p1;
   logic                vld_a_p1;
   logic                vld_b_p1;
   logic [width_a-1:0]  q_a_p1;
   logic [width_a-1:0]  q_b_p1;

   // While reset is held the ports are frozen, so neither write nor read occurs.
   assign port_en_a = enable_a & reset_n;
   assign port_en_b = enable_b & reset_n;
   assign wr_en_a   = port_en_a & wren_a;
   assign wr_en_b   = port_en_b & wren_b;

   // ---- stage p0 -> p1: array access (no reset, so the tools keep it in BRAM)
   // The raw read registers sample the array with non-blocking semantics, which
   // gives read-first behaviour for same-port and cross-port collisions alike.
   // Port B's write is issued after port A's, so B wins a same-address collision.
   always_ff @(posedge clk) begin
      if (port_en_a) begin
         if (wr_en_a) begin
            mem[address_a] <= data_a;
         end
         rd_a_p1 <= mem[address_a];
      end
      if (port_en_b) begin
         if (wr_en_b) begin
            mem[address_b] <= data_b;
         end
         rd_b_p1 <= mem[address_b];
      end
   end

   // Output-valid flags: low from reset until the first enabled edge, which
   // lets the raw read registers stay reset-free while q still reads 0.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vld_a_p1 <= 1'b0;
         vld_b_p1 <= 1'b0;
      end else begin
         if (enable_a) begin
            vld_a_p1 <= 1'b1;
         end
         if (enable_b) begin
            vld_b_p1 <= 1'b1;
         end
      end
   end

   // Output mux: force zero while the raw register holds pre-reset data.
   assign q_a_p1 = vld_a_p1 ? rd_a_p1 : '0;
   assign q_b_p1 = vld_b_p1 ? rd_b_p1 : '0;

`ifdef BRAM_OUTREG_EN
   logic [width_a-1:0] q_a_p2;
   logic [width_a-1:0] q_b_p2;

   // ---- stage p1 -> p2: optional output register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         q_a_p2 <= '0;
         q_b_p2 <= '0;
      end else begin
         if (enable_a) begin
            q_a_p2 <= q_a_p1;
         end
         if (enable_b) begin
            q_b_p2 <= q_b_p1;
         end
      end
   end

   assign q_a = q_a_p2;
   assign q_b = q_b_p2;
`else
   assign q_a = q_a_p1;
   assign q_b = q_b_p1;
`endif

endmodule

// File: tb/tb_bram_dp.sv
// -----------------------------------------------------------------------------
// tb_bram_dp
//   Self-checking bench for bram_dp: a table of directed port transactions,
//   hand-written reset and latency sequences, then randomized traffic checked
//   against a reference model (array plus per-port read-result pipeline).
//   Honours BRAM_OUTREG_EN (read latency 2) when defined.
// -----------------------------------------------------------------------------
module tb_bram_dp;
   import bram_pkg::*;

   localparam int DW = BRAM_DW;
   localparam int AW = BRAM_AW;
`ifdef BRAM_OUTREG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif
   localparam logic [DW-1:0] EXP_EDGE1 = (LAT == 2) ? 8'h00 : 8'h42;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic [AW-1:0] address_a = '0;
   logic [DW-1:0] data_a = '0;
   logic          wren_a = 1'b0;
   logic          enable_a = 1'b0;
   logic [DW-1:0] q_a;
   logic [AW-1:0] address_b = '0;
   logic [DW-1:0] data_b = '0;
   logic          wren_b = 1'b0;
   logic          enable_b = 1'b0;
   logic [DW-1:0] q_b;

   bram_dp #(.width_a(DW), .widthad_a(AW)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .address_a (address_a),
      .data_a    (data_a),
      .wren_a    (wren_a),
      .enable_a  (enable_a),
      .q_a       (q_a),
      .address_b (address_b),
      .data_b    (data_b),
      .wren_b    (wren_b),
      .enable_b  (enable_b),
      .q_b       (q_b)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: word array plus the last LAT read results per port.
   logic [DW-1:0] mem_m [0:(1<<AW)-1];
   logic [DW-1:0] pa1 = '0, pa2 = '0, pb1 = '0, pb2 = '0;

   typedef struct {
      logic          ea;
      logic          wa;
      logic [AW-1:0] aa;
      logic [DW-1:0] da;
      logic          eb;
      logic          wb;
      logic [AW-1:0] ab;
      logic [DW-1:0] db;
      logic [DW-1:0] xa;
      logic [DW-1:0] xb;
   } vec_t;

   vec_t tbl [12];

   task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%02h expected 0x%02h (t=%0t)", name, got, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] exp_a();
      return (LAT == 1) ? pa1 : pa2;
   endfunction

   function automatic logic [DW-1:0] exp_b();
      return (LAT == 1) ? pb1 : pb2;
   endfunction

   // Advance the model by what the coming edge should do, then take the edge
   // and return 1 ns later, where outputs are sampled and inputs changed.
   task automatic step();
      logic [DW-1:0] old_a;
      logic [DW-1:0] old_b;
      if (!reset_n) begin
         pa1 = '0; pa2 = '0; pb1 = '0; pb2 = '0;
      end else begin
         old_a = mem_m[address_a];
         old_b = mem_m[address_b];
         if (enable_a) begin pa2 = pa1; pa1 = old_a; end
         if (enable_b) begin pb2 = pb1; pb1 = old_b; end
         if (enable_a && wren_a) mem_m[address_a] = data_a;
         if (enable_b && wren_b) mem_m[address_b] = data_b;
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < (1 << AW); i++) mem_m[i] = '0;

      //             ea    wa    aa       da     eb    wb    ab       db     xa     xb
      tbl[0]  = '{1'b1, 1'b1, 10'h012, 8'h3C, 1'b1, 1'b0, 10'h005, 8'h00, 8'h00, 8'h00};
      tbl[1]  = '{1'b1, 1'b1, 10'h007, 8'h11, 1'b1, 1'b0, 10'h012, 8'h00, 8'h00, 8'h3C};
      tbl[2]  = '{1'b1, 1'b1, 10'h007, 8'hAA, 1'b1, 1'b0, 10'h007, 8'h00, 8'h11, 8'h11};
      tbl[3]  = '{1'b1, 1'b0, 10'h007, 8'h00, 1'b1, 1'b1, 10'h005, 8'h99, 8'hAA, 8'h00};
      tbl[4]  = '{1'b1, 1'b1, 10'h100, 8'h55, 1'b1, 1'b1, 10'h100, 8'h66, 8'h00, 8'h00};
      tbl[5]  = '{1'b1, 1'b0, 10'h100, 8'h00, 1'b1, 1'b0, 10'h100, 8'h00, 8'h66, 8'h66};
      tbl[6]  = '{1'b1, 1'b1, 10'h3FF, 8'h01, 1'b1, 1'b1, 10'h000, 8'h02, 8'h00, 8'h00};
      tbl[7]  = '{1'b1, 1'b0, 10'h000, 8'h00, 1'b1, 1'b0, 10'h3FF, 8'h00, 8'h02, 8'h01};
      tbl[8]  = '{1'b1, 1'b0, 10'h005, 8'h00, 1'b0, 1'b1, 10'h3FF, 8'hFF, 8'h99, 8'h01};
      tbl[9]  = '{1'b1, 1'b0, 10'h3FF, 8'h00, 1'b1, 1'b0, 10'h3FF, 8'h00, 8'h01, 8'h01};
      tbl[10] = '{1'b1, 1'b0, 10'h012, 8'h00, 1'b1, 1'b1, 10'h012, 8'h77, 8'h3C, 8'h3C};
      tbl[11] = '{1'b1, 1'b0, 10'h012, 8'h00, 1'b1, 1'b0, 10'h100, 8'h00, 8'h77, 8'h66};

      // Reset state
      #2;
      check("reset_q_a", q_a, 8'h00);
      check("reset_q_b", q_b, 8'h00);
      step();
      step();
      reset_n = 1'b1;

      // Directed table: each row is one edge, then LAT-1 hold edges with writes off.
      for (int i = 0; i < 12; i++) begin
         enable_a = tbl[i].ea; wren_a = tbl[i].wa; address_a = tbl[i].aa; data_a = tbl[i].da;
         enable_b = tbl[i].eb; wren_b = tbl[i].wb; address_b = tbl[i].ab; data_b = tbl[i].db;
         step();
         wren_a = 1'b0;
         wren_b = 1'b0;
         for (int k = 1; k < LAT; k++) step();
         check($sformatf("vec%0d_q_a", i), q_a, tbl[i].xa);
         check($sformatf("vec%0d_q_b", i), q_b, tbl[i].xb);
      end

      // Async reset mid-cycle, with write attempts at addr 5 during reset.
      enable_a = 1'b1; wren_a = 1'b1; address_a = 10'h005; data_a = 8'hEE;
      enable_b = 1'b1; wren_b = 1'b1; address_b = 10'h005; data_b = 8'hEE;
      reset_n = 1'b0;
      #1;
      check("rst_async_q_a", q_a, 8'h00);
      check("rst_async_q_b", q_b, 8'h00);
      step();
      check("rst_hold_q_a", q_a, 8'h00);
      check("rst_hold_q_b", q_b, 8'h00);
      reset_n = 1'b1;
      wren_a = 1'b0;
      wren_b = 1'b0;
      for (int k = 0; k < LAT; k++) step();
      check("rst_release_q_a", q_a, 8'h99);
      check("rst_release_q_b", q_b, 8'h99);

      // Read latency: write 0x42 at addr 3, then read it back on port A.
      enable_b = 1'b0;
      address_a = 10'h003; data_a = 8'h42; wren_a = 1'b1;
      step();
      wren_a = 1'b0;
      step();
      check("lat_edge1_q_a", q_a, EXP_EDGE1);
      step();
      check("lat_edge2_q_a", q_a, 8'h42);

      // Randomized traffic, concentrated on a few addresses to force collisions.
      for (int c = 0; c < 800; c++) begin
         reset_n   = ($urandom_range(0, 99) != 0);
         enable_a  = ($urandom_range(0, 3) != 0);
         wren_a    = $urandom_range(0, 1);
         address_a = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
         data_a    = DW'($urandom);
         enable_b  = ($urandom_range(0, 3) != 0);
         wren_b    = $urandom_range(0, 1);
         address_b = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
         data_b    = DW'($urandom);
         step();
         check("rnd_q_a", q_a, exp_a());
         check("rnd_q_b", q_b, exp_b());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
